// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage.
//   fetch_state_t : fetch controller FSM states (HALT is reachable only when the
//                   controller is built with FETCH_HALT_EN defined)
//   PC_W, INSTR_W : program counter and instruction word widths
//   HALT_INSTR    : instruction word that parks the controller when halting is enabled
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and flush controls.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_hold              : keep current contents (stall)
//   i_flush             : load a bubble {NOP_INSTR, 0, valid=0}; wins over i_hold
//   i_instr, i_pc1      : fetched instruction and its PC+1
//   o_instr, o_pc1      : registered instruction / PC+1
//   o_valid             : register holds a real instruction
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_hold,
  input  logic               i_flush,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc1,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc1,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc1;
  logic               r_valid;

  // Reset and flush leave the same bubble behind.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_instr <= NOP_INSTR;
      r_pc1   <= '0;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_instr <= i_instr;
      r_pc1   <= i_pc1;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc1   = r_pc1;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencing controller: owns the PC, fills the IF/ID register,
// and applies stall / branch-redirect / optional halt control.
// Optional feature macro: FETCH_HALT_EN (enables HALT on instruction 32'hFFFF_FFFF).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   stall           : hold PC and IF/ID
//   branch_taken    : redirect PC to branch_target and squash IF/ID
//   branch_target   : redirect address
//   instr_in        : fetched instruction for current pc (combinational from pc)
//   pc_plus1_in     : pc+1 from the fetch-stage adder
//   pc              : registered program counter
//   if_id_instr/pc1/valid : IF/ID register contents
//   halted          : controller parked in HALT (tied 0 without FETCH_HALT_EN)
module fetch_controller
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_plus1_in,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc1,
  output logic               if_id_valid,
  output logic               halted
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic            w_hold;
  logic            w_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_hold       = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      BOOT: begin
        // One settling cycle; redirect and stall requests are not yet meaningful.
        w_state_next = RUN;
        w_flush      = 1'b1;
      end
      RUN: begin
        if (branch_taken) begin
          w_pc_next = branch_target;
          w_flush   = 1'b1;
        end else if (stall) begin
          w_hold = 1'b1;
        end else begin
`ifdef FETCH_HALT_EN
          // The halt word is latched like any fetch, but the PC stops on it.
          if (instr_in == HALT_INSTR) begin
            w_state_next = HALT;
          end else begin
            w_pc_next = pc_plus1_in;
          end
`else
          w_pc_next = pc_plus1_in;
`endif
        end
      end
`ifdef FETCH_HALT_EN
      HALT: begin
        w_flush = 1'b1;
      end
`endif
      default: begin
        // Unreachable encodings fall back to a clean boot.
        w_state_next = BOOT;
        w_flush      = 1'b1;
      end
    endcase
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (w_hold),
    .i_flush (w_flush),
    .i_instr (instr_in),
    .i_pc1   (pc_plus1_in),
    .o_instr (if_id_instr),
    .o_pc1   (if_id_pc1),
    .o_valid (if_id_valid)
  );

  assign pc = r_pc;

`ifdef FETCH_HALT_EN
  assign halted = (r_state == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [31:0] instr_in;
  logic [15:0] pc_plus1_in;
  logic [15:0] pc;
  logic [31:0] if_id_instr;
  logic [15:0] if_id_pc1;
  logic        if_id_valid;
  logic        halted;

  logic        ovr_en;
  logic [31:0] ovr;

  int checks;
  int errors;

  fetch_controller #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_in      (instr_in),
    .pc_plus1_in   (pc_plus1_in),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc1     (if_id_pc1),
    .if_id_valid   (if_id_valid),
    .halted        (halted)
  );

  // Fetch-stage model: address-tagged instruction memory and PC+1 adder.
  assign instr_in    = ovr_en ? ovr : {16'hC0DE, pc};
  assign pc_plus1_in = pc + 16'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic [15:0] e_pc;
    logic [31:0] e_instr;
    logic [15:0] e_pc1;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic r, input logic s, input logic b, input logic [15:0] t,
                      input logic [15:0] epc, input logic [31:0] ei, input logic [15:0] ep1,
                      input logic ev);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.tgt = t;
    v.e_pc = epc; v.e_instr = ei; v.e_pc1 = ep1; v.e_valid = ev;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] epc, input logic [31:0] ei,
                           input logic [15:0] ep1, input logic ev, input logic eh);
    chk({tag, ".pc"},    {16'h0, pc},          {16'h0, epc});
    chk({tag, ".instr"}, if_id_instr,          ei);
    chk({tag, ".pc1"},   {16'h0, if_id_pc1},   {16'h0, ep1});
    chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, ev});
    chk({tag, ".halted"},{31'h0, halted},      {31'h0, eh});
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [15:0] t);
    rst = r; stall = s; branch_taken = b; branch_target = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ovr_en = 1'b0;
    ovr    = 32'h0;
    drive(1'b1, 1'b0, 1'b0, 16'h0);

    //   rst  stall br   tgt       pc        instr          pc1       valid
    addv(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'h0000_0000, 16'h0000, 1'b0); // reset
    addv(1'b0, 1'b1, 1'b1, 16'h0033, 16'h0000, 32'h0000_0000, 16'h0000, 1'b0); // BOOT ignores br/stall
    addv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 32'hC0DE_0000, 16'h0001, 1'b1);
    addv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 32'hC0DE_0001, 16'h0002, 1'b1);
    addv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, 32'hC0DE_0002, 16'h0003, 1'b1);
    addv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 32'hC0DE_0003, 16'h0004, 1'b1);
    addv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0005, 32'hC0DE_0004, 16'h0005, 1'b1);
    addv(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0005, 32'hC0DE_0004, 16'h0005, 1'b1); // stall x3
    addv(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0005, 32'hC0DE_0004, 16'h0005, 1'b1);
    addv(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0005, 32'hC0DE_0004, 16'h0005, 1'b1);
    addv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0006, 32'hC0DE_0005, 16'h0006, 1'b1); // resume
    addv(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0010, 32'h0000_0000, 16'h0000, 1'b0); // redirect
    addv(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0040, 32'h0000_0000, 16'h0000, 1'b0); // branch beats stall
    addv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0041, 32'hC0DE_0040, 16'h0041, 1'b1);
    addv(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0000, 16'h0000, 1'b0);
    addv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'hC0DE_FFFF, 16'h0000, 1'b1); // wrap
    addv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 32'hC0DE_0000, 16'h0001, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc1,
                vecs[i].e_valid, 1'b0);
    end

    // Halt word at pc=0007.
    drive(1'b0, 1'b0, 1'b1, 16'h0007);
    step();
    check_all("to7", 16'h0007, 32'h0, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    ovr_en = 1'b1;
    ovr    = 32'hFFFF_FFFF;
    step();
    ovr_en = 1'b0;
`ifdef FETCH_HALT_EN
    chk("halt.latch.pc",    {16'h0, pc},          32'h0000_0007);
    chk("halt.latch.instr", if_id_instr,          32'hFFFF_FFFF);
    chk("halt.latch.pc1",   {16'h0, if_id_pc1},   32'h0000_0008);
    chk("halt.latch.valid", {31'h0, if_id_valid}, 32'h1);
    step();
    check_all("halt.park", 16'h0007, 32'h0, 16'h0000, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 16'h0050);
    step();
    check_all("halt.ignbr", 16'h0007, 32'h0, 16'h0000, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    check_all("halt.stay", 16'h0007, 32'h0, 16'h0000, 1'b0, 1'b1);
`else
    check_all("ffff.ord", 16'h0008, 32'hFFFF_FFFF, 16'h0008, 1'b1, 1'b0);
    step();
    check_all("ffff.next", 16'h0009, 32'hC0DE_0008, 16'h0009, 1'b1, 1'b0);
`endif
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    check_all("rst.after.halt", 16'h0000, 32'h0, 16'h0000, 1'b0, 1'b0);

    // Reset asserted during a redirect at pc=0020.
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    drive(1'b0, 1'b0, 1'b1, 16'h0020);
    step();
    check_all("mr.to20", 16'h0020, 32'h0, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    check_all("mr.fetch20", 16'h0021, 32'hC0DE_0020, 16'h0021, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 16'h0060);
    step();
    check_all("mr.rst", 16'h0000, 32'h0, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 16'h0070);
    step();
    check_all("mr.boot", 16'h0000, 32'h0, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    check_all("mr.run", 16'h0001, 32'hC0DE_0000, 16'h0001, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
